load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: core presents an access.
REQ-004 SHALL have port req_ready, output, 1 bit: unit accepts a request this cycle.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr, input, 32 bits: byte address.
REQ-007 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-008 SHALL have port req_mode, input, 3 bits: funct3 encoding (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32 bits: extended load result; 0 for stores and errors.
REQ-011 SHALL have port resp_error, output, 1 bit: access rejected; valid while resp_valid=1.
REQ-012 SHALL have ports mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_mode (output, 3) and mem_rdata (input, 32), all connecting to data_memory32.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, SPLIT and RESP.
REQ-014 SHALL assert req_ready only in IDLE with rst low; a request is accepted when req_valid and req_ready are both high, and all req_* fields are latched.
REQ-015 SHALL treat a request as invalid if: mode[1:0]=11; or mode=110; or req_write=1 with mode[2]=1.
REQ-016 SHALL treat a request as out of range if addr + size - 1 > 1023, where size = 1, 2 or 4 bytes.
REQ-017 SHALL treat a request as misaligned if a halfword has addr[0]=1 or a word has addr[1:0]!=00.
REQ-018 SHALL route an accepted request that is invalid or out of range to RESP with resp_error=1; the memory is never written for such a request.
REQ-019 SHALL route an aligned, valid request to ACCESS for exactly one cycle, then to RESP.
REQ-020 SHALL, in ACCESS, drive mem_addr, mem_mode and mem_wdata from the latched request.
REQ-021 SHALL, in ACCESS, set mem_we equal to the latched write flag.
REQ-022 SHALL, in ACCESS for a load, capture mem_rdata into resp_rdata on the same cycle, because the memory read is combinational.
REQ-023 SHALL produce resp_valid=1 for exactly one cycle, in RESP, two cycles after acceptance for an aligned access; the following cycle SHALL be IDLE.
REQ-024 SHALL hold mem_we=0 in every state other than ACCESS and SPLIT, and whenever rst=1.
REQ-025 SHALL drive mem_addr, mem_wdata and mem_mode to 0 whenever the unit is not issuing an access.
REQ-026 SHALL treat the memory as big-endian: the lowest address holds the most significant byte.
REQ-027 SHALL ignore req_valid while not in IDLE; there is no back-to-back acceptance.

Reset
REQ-028 SHALL, on a rising edge with rst=1, set state to IDLE and clear resp_valid, resp_error and resp_rdata to 0.
REQ-029 SHALL drop an in-flight request on reset without producing a response; a partial split store may leave bytes already written.
REQ-030 SHALL set req_ready to 1 on the first cycle after rst is deasserted.

Configuration
REQ-031 SHALL support compile macro LSU_MISALIGN_SPLIT_EN.
REQ-032 SHALL, when LSU_MISALIGN_SPLIT_EN is undefined, treat a misaligned request as an error: RESP with resp_error=1 and no memory write.
REQ-033 SHALL, when LSU_MISALIGN_SPLIT_EN is defined, route a valid misaligned request to SPLIT instead of raising an error.
REQ-034 SHALL, in SPLIT, issue `size` byte accesses at addr+k, k = 0 .. size-1, one per cycle, using mem_mode=100 for loads and 000 for stores.
REQ-035 SHALL, in SPLIT for stores, write bytes MSB first.
REQ-036 SHALL, in SPLIT for loads, assemble the result as acc = {acc[23:0], byte}, then sign- or zero-extend it per req_mode.
REQ-037 SHALL go to RESP after the last byte, giving a split-access latency of size + 1 cycles from acceptance.

Verification
REQ-038 SHALL cover: SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF, resp_error=0, resp_valid two cycles after acceptance.
REQ-039 SHALL cover: SB 0x20 data 0x80, then LB 0x20 -> resp_rdata=0xFFFFFF80; LBU 0x20 -> resp_rdata=0x00000080.
REQ-040 SHALL cover: LW addr 1021 -> resp_error=1, mem_we never asserted.
REQ-041 SHALL cover: LH addr 0x31 -> without the macro, resp_error=1; with the macro and bytes 0x31=0x92, 0x32=0x34 -> resp_rdata=0xFFFF9234 after 3 cycles.
REQ-042 SHALL cover: rst asserted in the cycle a store enters ACCESS -> mem_we=0, no resp_valid, memory unchanged, req_ready=1 after release.
REQ-043 SHALL cover: req_valid held high through a full transaction -> exactly one acceptance per IDLE visit, no spurious second response.

Source files
------------

// File: rtl/load_store_unit.sv
//==============================================================================
// load_store_unit
// Load/store unit between the core and a 1 KiB big-endian data_memory32.
// Optional macro LSU_MISALIGN_SPLIT_EN: split misaligned accesses into byte accesses.
// Revision: 1.0
//==============================================================================
`default_nettype none

module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mode,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_mode,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_SPLIT  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [32:0] c_ADDR_MAX = 33'd1023;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_mode;
    logic [1:0]  r_cnt;
    logic [31:0] r_acc;

    logic [2:0]  w_size;
    logic [2:0]  w_rsize;
    logic [32:0] w_end;
    logic        w_invalid;
    logic        w_oor;
    logic        w_misal;
    logic        w_req_err;
    logic        w_accept;
    logic        w_last;
    logic [1:0]  w_bidx;
    logic [7:0]  w_split_byte;
    logic [31:0] w_acc_next;

    function automatic logic [2:0] f_size(input logic [2:0] m);
        case (m[1:0])
            2'b00:   f_size = 3'd1;
            2'b01:   f_size = 3'd2;
            default: f_size = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [2:0] m);
        case (m)
            3'b000:  f_extend = {{24{d[7]}}, d[7:0]};
            3'b001:  f_extend = {{16{d[15]}}, d[15:0]};
            3'b100:  f_extend = {24'd0, d[7:0]};
            3'b101:  f_extend = {16'd0, d[15:0]};
            default: f_extend = d;
        endcase
    endfunction

    // Request classification on the incoming (not yet latched) fields
    assign w_size    = f_size(req_mode);
    assign w_end     = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
    assign w_invalid = (req_mode[1:0] == 2'b11) || (req_mode == 3'b110) || (req_write && req_mode[2]);
    assign w_oor     = (w_end > c_ADDR_MAX);
    assign w_misal   = ((req_mode[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_mode[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_req_err = w_invalid || w_oor;
`else
    assign w_req_err = w_invalid || w_oor || w_misal;
`endif

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // Split stores walk the right-aligned data from its most significant byte down
    assign w_rsize    = f_size(r_mode);
    assign w_bidx     = w_rsize[1:0] - 2'd1 - r_cnt;
    assign w_last     = ({1'b0, r_cnt} == (w_rsize - 3'd1));
    assign w_acc_next = {r_acc[23:0], mem_rdata[7:0]};

    always_comb begin
        case (w_bidx)
            2'd0:    w_split_byte = r_wdata[7:0];
            2'd1:    w_split_byte = r_wdata[15:8];
            2'd2:    w_split_byte = r_wdata[23:16];
            default: w_split_byte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_mode  = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next = S_RESP;
                    end else if (w_misal) begin
                        w_next = S_SPLIT;
                    end else begin
                        w_next = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                mem_we    = r_write;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                mem_mode  = r_mode;
                w_next    = S_RESP;
            end
            S_SPLIT: begin
                mem_we    = r_write;
                mem_addr  = r_addr + {30'd0, r_cnt};
                mem_wdata = {24'd0, w_split_byte};
                mem_mode  = r_write ? 3'b000 : 3'b100;
                if (w_last) begin
                    w_next = S_RESP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Reset must cut a store off even in the cycle it would have written
        if (rst) begin
            mem_we    = 1'b0;
            mem_addr  = 32'd0;
            mem_wdata = 32'd0;
            mem_mode  = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'd0;
            r_write    <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_mode     <= 3'd0;
            r_cnt      <= 2'd0;
            r_acc      <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_mode  <= req_mode;
                        r_cnt   <= 2'd0;
                        r_acc   <= 32'd0;
                        if (w_req_err) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= r_write ? 32'd0 : f_extend(mem_rdata, r_mode);
                end
                S_SPLIT: begin
                    r_cnt <= r_cnt + 2'd1;
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= r_write ? 32'd0 : f_extend(w_acc_next, r_mode);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// tb_load_store_unit
// Directed self-checking bench for load_store_unit with a big-endian memory model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mode;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mode;
    logic [31:0] mem_rdata;

    int checks;
    int passed;
    int we_cnt;

    logic [7:0] mem [0:1023];
    logic [9:0] ra;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mode   (req_mode),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mode   (mem_mode),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian memory: combinational read, write on the rising edge
    always_comb begin
        ra = mem_addr[9:0];
        case (mem_mode[1:0])
            2'b00:   mem_rdata = {24'd0, mem[ra]};
            2'b01:   mem_rdata = {16'd0, mem[ra], mem[ra + 10'd1]};
            default: mem_rdata = {mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            case (mem_mode[1:0])
                2'b00: mem[mem_addr[9:0]] <= mem_wdata[7:0];
                2'b01: begin
                    mem[mem_addr[9:0]]         <= mem_wdata[15:8];
                    mem[mem_addr[9:0] + 10'd1] <= mem_wdata[7:0];
                end
                default: begin
                    mem[mem_addr[9:0]]         <= mem_wdata[31:24];
                    mem[mem_addr[9:0] + 10'd1] <= mem_wdata[23:16];
                    mem[mem_addr[9:0] + 10'd2] <= mem_wdata[15:8];
                    mem[mem_addr[9:0] + 10'd3] <= mem_wdata[7:0];
                end
            endcase
        end
    end

    // Issues one request from a falling edge; lat counts cycles from the acceptance cycle.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] m, output int lat, output logic [31:0] rd,
                          output logic er);
        lat = -1;
        rd  = 32'hxxxxxxxx;
        er  = 1'bx;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_mode  = m;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_error;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else passed++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passed++;
        checks++; if (resp_error !== 1'b0) $display("FAIL reset_resp_error: got %b want 0", resp_error); else passed++;
        checks++; if (resp_rdata !== 32'd0) $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); else passed++;
        checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready); else passed++;
        @(negedge clk);
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, lat, rd, er);
        checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'd0)
            $display("FAIL sw_resp: lat %0d err %b rdata %h want lat 2 err 0 rdata 0", lat, er, rd); else passed++;
        checks++; if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF)
            $display("FAIL sw_bigendian: got %h want deadbeef", {mem[16], mem[17], mem[18], mem[19]}); else passed++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL sw_single_pulse: got %b want 0", resp_valid); else passed++;
        do_req(1'b0, 32'h10, 32'h0, 3'b010, lat, rd, er);
        checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF)
            $display("FAIL lw_resp: lat %0d err %b rdata %h want lat 2 err 0 rdata deadbeef", lat, er, rd); else passed++;
    endtask

    task automatic test_byte_half();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h20, 32'h00000080, 3'b000, lat, rd, er);
        checks++; if (mem[32] !== 8'h80) $display("FAIL sb_mem: got %h want 80", mem[32]); else passed++;
        do_req(1'b0, 32'h20, 32'h0, 3'b000, lat, rd, er);
        checks++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) $display("FAIL lb: got %h err %b want ffffff80", rd, er); else passed++;
        do_req(1'b0, 32'h20, 32'h0, 3'b100, lat, rd, er);
        checks++; if (rd !== 32'h00000080 || er !== 1'b0) $display("FAIL lbu: got %h err %b want 00000080", rd, er); else passed++;
        do_req(1'b1, 32'h40, 32'hAAAA8001, 3'b001, lat, rd, er);
        do_req(1'b0, 32'h40, 32'h0, 3'b001, lat, rd, er);
        checks++; if (rd !== 32'hFFFF8001) $display("FAIL lh: got %h want ffff8001", rd); else passed++;
        do_req(1'b0, 32'h40, 32'h0, 3'b101, lat, rd, er);
        checks++; if (rd !== 32'h00008001) $display("FAIL lhu: got %h want 00008001", rd); else passed++;
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er; int we0;
        we0 = we_cnt;
        do_req(1'b0, 32'd1021, 32'h0, 3'b010, lat, rd, er);
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0)
            $display("FAIL lw_1021: lat %0d err %b rdata %h want lat 1 err 1 rdata 0", lat, er, rd); else passed++;
        do_req(1'b1, 32'd1021, 32'h12345678, 3'b010, lat, rd, er);
        checks++; if (er !== 1'b1) $display("FAIL sw_1021: err %b want 1", er); else passed++;
        do_req(1'b1, 32'h8, 32'h12345678, 3'b100, lat, rd, er);
        checks++; if (er !== 1'b1) $display("FAIL store_unsigned_mode: err %b want 1", er); else passed++;
        do_req(1'b0, 32'h8, 32'h0, 3'b011, lat, rd, er);
        checks++; if (er !== 1'b1) $display("FAIL mode_011: err %b want 1", er); else passed++;
        do_req(1'b0, 32'h8, 32'h0, 3'b110, lat, rd, er);
        checks++; if (er !== 1'b1) $display("FAIL mode_110: err %b want 1", er); else passed++;
        checks++; if (we_cnt !== we0) $display("FAIL error_no_write: writes %0d want 0", we_cnt - we0); else passed++;
        do_req(1'b1, 32'd1020, 32'hA1B2C3D4, 3'b010, lat, rd, er);
        do_req(1'b0, 32'd1020, 32'h0, 3'b010, lat, rd, er);
        checks++; if (er !== 1'b0 || rd !== 32'hA1B2C3D4)
            $display("FAIL lw_1020_edge: err %b rdata %h want err 0 rdata a1b2c3d4", er, rd); else passed++;
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic er; int we0;
        do_req(1'b1, 32'h31, 32'h92, 3'b000, lat, rd, er);
        do_req(1'b1, 32'h32, 32'h34, 3'b000, lat, rd, er);
        do_req(1'b0, 32'h31, 32'h0, 3'b001, lat, rd, er);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (lat !== 3 || er !== 1'b0 || rd !== 32'hFFFF9234)
            $display("FAIL lh_misal_split: lat %0d err %b rdata %h want lat 3 err 0 rdata ffff9234", lat, er, rd); else passed++;
        do_req(1'b1, 32'h51, 32'h11223344, 3'b010, lat, rd, er);
        checks++; if (lat !== 5 || er !== 1'b0)
            $display("FAIL sw_misal_split: lat %0d err %b want lat 5 err 0", lat, er); else passed++;
        checks++; if ({mem[81], mem[82], mem[83], mem[84]} !== 32'h11223344)
            $display("FAIL sw_misal_bytes: got %h want 11223344", {mem[81], mem[82], mem[83], mem[84]}); else passed++;
        do_req(1'b0, 32'h51, 32'h0, 3'b010, lat, rd, er);
        checks++; if (lat !== 5 || rd !== 32'h11223344)
            $display("FAIL lw_misal_split: lat %0d rdata %h want lat 5 rdata 11223344", lat, rd); else passed++;
`else
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0)
            $display("FAIL lh_misal_err: lat %0d err %b rdata %h want lat 1 err 1 rdata 0", lat, er, rd); else passed++;
        we0 = we_cnt;
        do_req(1'b1, 32'h51, 32'h11223344, 3'b010, lat, rd, er);
        checks++; if (er !== 1'b1 || we_cnt !== we0)
            $display("FAIL sw_misal_err: err %b writes %0d want err 1 writes 0", er, we_cnt - we0); else passed++;
`endif
    endtask

    task automatic test_reset_midflight();
        int lat; logic [31:0] rd; logic er; int we0; int nresp;
        do_req(1'b1, 32'h60, 32'h01020304, 3'b010, lat, rd, er);
        we0 = we_cnt;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h60;
        req_wdata = 32'hCAFEF00D;
        req_mode  = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) $display("FAIL midflight_we: got %b want 0", mem_we); else passed++;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) $display("FAIL midflight_resp: got %b want 0", resp_valid); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL midflight_ready: got %b want 1", req_ready); else passed++;
        nresp = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        checks++; if (nresp !== 0 || we_cnt !== we0)
            $display("FAIL midflight_quiet: responses %0d writes %0d want 0 0", nresp, we_cnt - we0); else passed++;
        checks++; if ({mem[96], mem[97], mem[98], mem[99]} !== 32'h01020304)
            $display("FAIL midflight_mem: got %h want 01020304", {mem[96], mem[97], mem[98], mem[99]}); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc; int rsp; int bad;
        acc = 0; rsp = 0; bad = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_mode  = 3'b010;
        for (int i = 0; i < 12; i++) begin
            if (req_valid && req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                if (resp_rdata !== 32'hDEADBEEF) bad++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (acc !== 4) $display("FAIL b2b_accepts: got %0d want 4", acc); else passed++;
        checks++; if (rsp !== 4 || bad !== 0)
            $display("FAIL b2b_responses: got %0d bad %0d want 4 bad 0", rsp, bad); else passed++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        we_cnt    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_mode  = 3'd0;
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_misalign();
        test_reset_midflight();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
